// File: rtl/fb_ctrl_pkg.sv
// Shared types and defaults for the still-frame capture controller.
// The helper saturates a counter at an upper bound.
package fb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBLANK,
    WAIT_FV,
    CAPTURE,
    READ_ISSUE,
    READ_WAIT,
    READ_HOLD
  } fb_ctrl_state_t;

  localparam int DEF_ADDR           = 12;
  localparam int DEF_DATA           = 10;
  localparam int DEF_RD_LAT         = 1;
  localparam int DEF_TIMEOUT_CYCLES = 2**20;

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fb_read_sequencer.sv
// Streams a captured frame out of the buffer one pixel at a time:
// issue address, wait out the read latency, hold the beat until accepted.
module fb_read_sequencer
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR   = DEF_ADDR,
  parameter int DATA   = DEF_DATA,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go_i,
  input  logic            abort_i,
  input  logic [ADDR:0]   len_i,
  output logic [ADDR-1:0] fb_rd_addr_o,
  input  logic [DATA-1:0] fb_rd_data_i,
  output logic [DATA-1:0] px_data_o,
  output logic            px_valid_o,
  input  logic            px_ready_i,
  output logic            px_last_o,
  output logic            busy_o,
  output logic            last_acc_o
);

  fb_ctrl_state_t  state_q, state_d;
  logic [ADDR:0]   idx_q, idx_d;
  logic [1:0]      lat_q, lat_d;
  logic [DATA-1:0] px_data_q, px_data_d;
  logic            px_valid_q, px_valid_d;
  logic            px_last_q, px_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lat_q      <= '0;
      px_data_q  <= '0;
      px_valid_q <= 1'b0;
      px_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      px_last_q  <= px_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    px_data_d  = px_data_q;
    px_valid_d = px_valid_q;
    px_last_d  = px_last_q;
    last_acc_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_i) begin
          idx_d   = '0;
          state_d = READ_ISSUE;
        end
      end
      READ_ISSUE: begin
        lat_d   = '0;
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        if (lat_q == 2'(RD_LAT - 1)) begin
          px_data_d  = fb_rd_data_i;
          px_valid_d = 1'b1;
          px_last_d  = (idx_q == len_i - (ADDR+1)'(1));
          state_d    = READ_HOLD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      READ_HOLD: begin
        if (px_ready_i) begin
          px_valid_d = 1'b0;
          px_last_d  = 1'b0;
          if (px_last_q) begin
            last_acc_o = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d   = idx_q + (ADDR+1)'(1);
            state_d = READ_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a beat being accepted this cycle.
    if (abort_i) begin
      state_d    = IDLE;
      px_valid_d = 1'b0;
      px_last_d  = 1'b0;
      last_acc_o = 1'b0;
    end
  end

  assign fb_rd_addr_o = idx_q[ADDR-1:0];
  assign px_data_o    = px_data_q;
  assign px_valid_o   = px_valid_q;
  assign px_last_o    = px_last_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/frame_capture_ctrl.sv
// Arms the frame buffer for exactly one camera frame, counts its pixels,
// then hands readout to fb_read_sequencer.
module frame_capture_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR           = DEF_ADDR,
  parameter int DATA           = DEF_DATA,
  parameter int RD_LAT         = DEF_RD_LAT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            fv_i,
  input  logic            lv_i,
  output logic            fb_rd_en_o,
  output logic [ADDR-1:0] fb_rd_addr_o,
  input  logic [DATA-1:0] fb_rd_data_i,
  output logic [DATA-1:0] px_data_o,
  output logic            px_valid_o,
  input  logic            px_ready_i,
  output logic            px_last_o,
  output logic [ADDR:0]   frame_len_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  localparam int DEPTH = 1 << ADDR;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  fb_ctrl_state_t  state_q, state_d;
  logic [ADDR:0]   pix_cnt_q, pix_cnt_d;
  logic [ADDR:0]   frame_len_q, frame_len_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            seq_go, seq_busy, seq_last_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      frame_len_q <= '0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_len_q <= frame_len_d;
      to_cnt_q    <= to_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    frame_len_d = frame_len_q;
    to_cnt_d    = to_cnt_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    seq_go      = 1'b0;
    case (state_q)
      IDLE: begin
        // The readout phase still counts as busy, so no new capture starts under it.
        if (start_i && !seq_busy) begin
          pix_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = WAIT_VBLANK;
        end
      end
      WAIT_VBLANK, WAIT_FV: begin
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (state_q == WAIT_VBLANK && !fv_i) state_d = WAIT_FV;
          if (state_q == WAIT_FV && fv_i)      state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!fv_i) begin
          frame_len_d = pix_cnt_q;
          state_d     = IDLE;
          if (pix_cnt_q == '0) done_d = 1'b1;
          else                 seq_go = 1'b1;
        end else if (lv_i) begin
          pix_cnt_d = (ADDR+1)'(sat_inc(32'(pix_cnt_q), 32'(DEPTH)));
        end
      end
      default: state_d = IDLE;
    endcase
    if (seq_last_acc) done_d = 1'b1;
    if (abort_i) begin
      state_d     = IDLE;
      seq_go      = 1'b0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      frame_len_d = frame_len_q;
    end
  end

  fb_read_sequencer #(
    .ADDR   (ADDR),
    .DATA   (DATA),
    .RD_LAT (RD_LAT)
  ) u_read_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .go_i         (seq_go),
    .abort_i      (abort_i),
    .len_i        (frame_len_q),
    .fb_rd_addr_o (fb_rd_addr_o),
    .fb_rd_data_i (fb_rd_data_i),
    .px_data_o    (px_data_o),
    .px_valid_o   (px_valid_o),
    .px_ready_i   (px_ready_i),
    .px_last_o    (px_last_o),
    .busy_o       (seq_busy),
    .last_acc_o   (seq_last_acc)
  );

  // Buffer write side is live only while armed for the frame.
  assign fb_rd_en_o  = !(state_q == WAIT_FV || state_q == CAPTURE);
  assign frame_len_o = frame_len_q;
  assign busy_o      = (state_q != IDLE) || seq_busy;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: table-driven frame scenarios, hand-written
// timeout/abort/reset sequences and randomized frames against a frame-level model.
module tb_frame_capture_ctrl;
  localparam int ADDR = 12;
  localparam int DATA = 10;
  localparam int RD_LAT = 2;
  localparam int TMO = 100;
  localparam int DEPTH = 1 << ADDR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, fv_i = 1'b0, lv_i = 1'b0, px_ready_i = 1'b0;
  logic fb_rd_en_o;
  logic [ADDR-1:0] fb_rd_addr_o;
  logic [DATA-1:0] fb_rd_data_i, px_data_o;
  logic px_valid_o, px_last_o, busy_o, done_o, timeout_o;
  logic [ADDR:0] frame_len_o;

  frame_capture_ctrl #(.ADDR(ADDR), .DATA(DATA), .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .fv_i(fv_i), .lv_i(lv_i),
    .fb_rd_en_o(fb_rd_en_o), .fb_rd_addr_o(fb_rd_addr_o), .fb_rd_data_i(fb_rd_data_i),
    .px_data_o(px_data_o), .px_valid_o(px_valid_o), .px_ready_i(px_ready_i),
    .px_last_o(px_last_o), .frame_len_o(frame_len_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int buf_word(int a);
    return (a * 29 + 7 + (a >> 10) * 3) % 1024;
  endfunction

  // Buffer RAM model with RD_LAT = 2 cycles from address to data.
  logic [DATA-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= DATA'(buf_word(int'(fb_rd_addr_o)));
    rd_p1 <= rd_p0;
  end
  assign fb_rd_data_i = rd_p1;

  int n_checks = 0;
  int n_pass = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {int addr; int data; bit last; int cyc;} beat_t;
  beat_t beats[$];
  int done_cycs[$];
  int to_cycs[$];
  int valid_cycles = 0;

  task automatic clear_mon();
    beats.delete();
    done_cycs.delete();
    to_cycs.delete();
    valid_cycles = 0;
  endtask

  initial begin : monitor
    bit pending;
    int p_addr, p_data;
    bit p_last;
    beat_t b;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          chk("hold_valid", px_valid_o, 1);
          chk("hold_data", px_data_o, p_data);
          chk("hold_addr", fb_rd_addr_o, p_addr);
          chk("hold_last", px_last_o, p_last);
        end
        if (done_o) done_cycs.push_back(cyc);
        if (timeout_o) to_cycs.push_back(cyc);
        if (px_valid_o) valid_cycles++;
        if (px_valid_o && px_ready_i && !abort_i) begin
          b.addr = int'(fb_rd_addr_o);
          b.data = int'(px_data_o);
          b.last = px_last_o;
          b.cyc = cyc;
          beats.push_back(b);
        end
        pending = px_valid_o && !px_ready_i && !abort_i;
        p_addr = int'(fb_rd_addr_o);
        p_data = int'(px_data_o);
        p_last = px_last_o;
      end
    end
  end

  task automatic check_frame(input string nm, input int exp_len);
    chk({nm, "_len"}, frame_len_o, exp_len);
    chk({nm, "_beats"}, beats.size(), exp_len);
    for (int i = 0; i < beats.size(); i++) begin
      chk({nm, "_addr"}, beats[i].addr, i);
      chk({nm, "_data"}, beats[i].data, buf_word(i));
      chk({nm, "_last"}, beats[i].last, (i == exp_len - 1) ? 1 : 0);
    end
    chk({nm, "_done_cnt"}, done_cycs.size(), 1);
    if (beats.size() > 0 && done_cycs.size() > 0)
      chk({nm, "_done_cyc"}, done_cycs[0], beats[beats.size()-1].cyc + 1);
    if (exp_len == 0) chk({nm, "_no_valid"}, valid_cycles, 0);
    chk({nm, "_no_timeout"}, to_cycs.size(), 0);
  endtask

  task automatic wait_readout(input int stall_beat, input int stall_len);
    int stall_left;
    bit finished;
    stall_left = stall_len;
    finished = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (px_valid_o && beats.size() == stall_beat && stall_left > 0) begin
        px_ready_i = 1'b0;
        stall_left--;
        chk("stall_addr", fb_rd_addr_o, stall_beat);
      end else begin
        px_ready_i = 1'b1;
      end
      tick();
      if (done_cycs.size() > 0 || to_cycs.size() > 0) begin
        finished = 1'b1;
        break;
      end
    end
    chk("readout_finished", finished, 1);
    px_ready_i = 1'b1;
    repeat (3) tick();
  endtask

  typedef struct {
    string name;
    int mid_lv;
    int lines;
    int width;
    int stall_beat;
    int stall_len;
    int exp_len;
  } vec_t;

  task automatic run_vec(input vec_t v);
    clear_mon();
    px_ready_i = 1'b1;
    if (v.mid_lv > 0) begin
      fv_i = 1'b1; lv_i = 1'b0;
      repeat (2) tick();
      start_i = 1'b1; lv_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (v.mid_lv - 1) tick();
      lv_i = 1'b0;
      tick();
    end else begin
      fv_i = 1'b0; lv_i = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    fv_i = 1'b0; lv_i = 1'b0;
    repeat (3) tick();
    fv_i = 1'b1;
    repeat (2) tick();
    for (int l = 0; l < v.lines; l++) begin
      lv_i = 1'b1;
      repeat (v.width) tick();
      lv_i = 1'b0;
      repeat (2) tick();
    end
    fv_i = 1'b0;
    tick();
    wait_readout(v.stall_beat, v.stall_len);
    check_frame(v.name, v.exp_len);
  endtask

  bit g_fv[$];
  bit g_lv[$];

  task automatic push_frame();
    int porch, lines, w, gap, vb;
    porch = $urandom_range(1, 2);
    repeat (porch) begin g_fv.push_back(1'b1); g_lv.push_back(1'b0); end
    lines = $urandom_range(0, 4);
    for (int l = 0; l < lines; l++) begin
      w = $urandom_range(1, 6);
      gap = $urandom_range(1, 3);
      repeat (w) begin g_fv.push_back(1'b1); g_lv.push_back(1'b1); end
      repeat (gap) begin g_fv.push_back(1'b1); g_lv.push_back(1'b0); end
    end
    vb = $urandom_range(2, 8);
    repeat (vb) begin g_fv.push_back(1'b0); g_lv.push_back($urandom_range(0, 3) == 0); end
  endtask

  task automatic run_random(input int it);
    int s, c, f, len, lim;
    bit exp_to, finished;
    string nm;
    nm = $sformatf("rand%0d", it);
    g_fv.delete();
    g_lv.delete();
    repeat ($urandom_range(0, 3)) begin g_fv.push_back(1'b0); g_lv.push_back(1'b0); end
    repeat (3) push_frame();
    lim = g_fv.size() / 3;
    if (lim > 15) lim = 15;
    s = $urandom_range(0, lim);
    // Capture starts on the first fv rising edge seen once the armed controller has left IDLE.
    c = -1;
    for (int k = s + 2; k < g_fv.size(); k++)
      if (g_fv[k] && !g_fv[k-1]) begin c = k; break; end
    exp_to = (c < 0) || (c - s >= TMO);
    len = 0;
    f = g_fv.size();
    if (!exp_to) begin
      for (int k = c + 1; k < g_fv.size(); k++) begin
        if (!g_fv[k]) begin f = k; break; end
        if (g_lv[k] && len < DEPTH) len++;
      end
    end
    clear_mon();
    for (int k = 0; k < g_fv.size(); k++) begin
      fv_i = g_fv[k];
      lv_i = g_lv[k];
      start_i = (k == s) || (k > s && !exp_to && k < f && $urandom_range(0, 15) == 0);
      px_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    start_i = 1'b0; fv_i = 1'b0; lv_i = 1'b0;
    finished = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (done_cycs.size() > 0 || to_cycs.size() > 0) begin finished = 1'b1; break; end
      px_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk({nm, "_finished"}, finished, 1);
    px_ready_i = 1'b1;
    repeat (3) tick();
    if (exp_to) begin
      chk({nm, "_timeout"}, to_cycs.size(), 1);
      chk({nm, "_no_done"}, done_cycs.size(), 0);
    end else begin
      check_frame(nm, len);
    end
  endtask

  vec_t vecs[5];

  initial begin : main
    int c0;
    bit found;
    vecs[0] = '{name: "t1_12px",     mid_lv: 0, lines: 3, width: 4,    stall_beat: -1, stall_len: 0, exp_len: 12};
    vecs[1] = '{name: "t2_midframe", mid_lv: 7, lines: 2, width: 5,    stall_beat: -1, stall_len: 0, exp_len: 10};
    vecs[2] = '{name: "t3_stall",    mid_lv: 0, lines: 2, width: 4,    stall_beat: 2,  stall_len: 5, exp_len: 8};
    vecs[3] = '{name: "t6_sat",      mid_lv: 0, lines: 1, width: 5000, stall_beat: -1, stall_len: 0, exp_len: 4096};
    vecs[4] = '{name: "t6_empty",    mid_lv: 0, lines: 0, width: 0,    stall_beat: -1, stall_len: 0, exp_len: 0};

    repeat (3) tick();
    chk("rst_rd_en", fb_rd_en_o, 1);
    chk("rst_addr", fb_rd_addr_o, 0);
    chk("rst_valid", px_valid_o, 0);
    chk("rst_last", px_last_o, 0);
    chk("rst_len", frame_len_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Frame-edge timeout with fv stuck low.
    clear_mon();
    fv_i = 1'b0; lv_i = 1'b0;
    c0 = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("t4_busy_wait", busy_o, 1);
    chk("t4_rd_en_wait", fb_rd_en_o, 0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (timeout_o) begin found = 1'b1; break; end
    end
    chk("t4_timeout_seen", found, 1);
    chk("t4_busy_after", busy_o, 0);
    chk("t4_rd_en_after", fb_rd_en_o, 1);
    repeat (4) tick();
    chk("t4_timeout_cnt", to_cycs.size(), 1);
    if (to_cycs.size() > 0) chk("t4_timeout_cyc", to_cycs[0], c0 + 1 + TMO);
    chk("t4_no_done", done_cycs.size(), 0);

    // Abort while beat 4 is being held.
    clear_mon();
    px_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    fv_i = 1'b1;
    repeat (2) tick();
    lv_i = 1'b1;
    repeat (8) tick();
    lv_i = 1'b0;
    tick();
    fv_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (px_valid_o && beats.size() == 3) begin found = 1'b1; break; end
      tick();
    end
    chk("t5_beat4_reached", found, 1);
    px_ready_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t5_valid_drop", px_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_rd_en", fb_rd_en_o, 1);
    repeat (5) tick();
    chk("t5_no_done", done_cycs.size(), 0);
    chk("t5_len_kept", frame_len_o, 8);
    chk("t5_beats", beats.size(), 3);

    // Asynchronous reset in the middle of capture.
    clear_mon();
    px_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    fv_i = 1'b1;
    tick();
    lv_i = 1'b1;
    repeat (3) tick();
    chk("t5r_capture_busy", busy_o, 1);
    chk("t5r_capture_rd_en", fb_rd_en_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_rd_en", fb_rd_en_o, 1);
    chk("t5r_addr", fb_rd_addr_o, 0);
    chk("t5r_data", px_data_o, 0);
    chk("t5r_valid", px_valid_o, 0);
    chk("t5r_last", px_last_o, 0);
    chk("t5r_len", frame_len_o, 0);
    chk("t5r_busy", busy_o, 0);
    chk("t5r_done", done_o, 0);
    chk("t5r_timeout", timeout_o, 0);
    fv_i = 1'b0; lv_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5r_post_busy", busy_o, 0);
    chk("t5r_post_done", done_cycs.size(), 0);
    chk("t5r_post_timeout", to_cycs.size(), 0);

    for (int it = 0; it < 6; it++) run_random(it);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences the line/frame capture buffer for one still frame: arm, capture, read out.
- On a host start it unfreezes the buffer write side for exactly one complete camera frame, counting the pixels written.
- Freezes the buffer again and streams the stored pixels to the host readout path (SPI/FIFO side) over a valid/ready interface.
- Sits between the camera sensor interface, the buffer RAM read port and the host command decoder.

Parameters:
ADDR, 12, buffer address width; buffer depth DEPTH = 2**ADDR
DATA, 10, pixel width
RD_LAT, 1, buffer read latency in clk cycles (address+enable to data), 1..3
TIMEOUT_CYCLES, 2**20, max cycles spent waiting for frame edges before abandoning

Ports:
clk  in  1  system clock; fv_i/lv_i are already synchronous to it
rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle capture request; honoured only in IDLE
abort_i  in  1  single-cycle abort; returns to IDLE from any state
fv_i  in  1  camera frame valid
lv_i  in  1  camera line valid
fb_rd_en_o  out  1  buffer read enable; high also holds the buffer write side in reset
fb_rd_addr_o  out  ADDR  buffer read address
fb_rd_data_i  in  DATA  buffer read data
px_data_o  out  DATA  readout pixel
px_valid_o  out  1  readout valid
px_ready_i  in  1  readout ready
px_last_o  out  1  marks final pixel of frame, qualified by px_valid_o
frame_len_o  out  ADDR+1  pixels captured in last frame, saturating at DEPTH
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after last pixel accepted or empty frame
timeout_o  out  1  one-cycle pulse on frame-edge timeout

Behaviour:
- Reset values: fb_rd_en_o=1, fb_rd_addr_o=0, px_data_o=0, px_valid_o=0, px_last_o=0, frame_len_o=0, busy_o=0, done_o=0, timeout_o=0, state=IDLE.
- fb_rd_en_o is low only in WAIT_FV and CAPTURE; high in every other state. This keeps the buffer from writing outside the armed frame.
- IDLE: start_i -> WAIT_VBLANK; clear pixel counter and timeout counter.
- WAIT_VBLANK: wait for fv_i=0. A start mid-frame therefore never captures a partial frame.
- WAIT_FV: wait for fv_i rising (fv_i=1) -> CAPTURE.
- Timeout counter runs in WAIT_VBLANK+WAIT_FV combined. Reaching TIMEOUT_CYCLES -> IDLE, timeout_o pulses, no done_o.
- CAPTURE: pixel counter increments each cycle lv_i=1, saturating at DEPTH.
- CAPTURE exit on fv_i=0: frame_len_o <= counter (registered that cycle).
  - Counter 0 -> IDLE with done_o pulse.
  - Counter nonzero -> READ_ISSUE with read index 0.
- READ_ISSUE: drive fb_rd_addr_o=index (fb_rd_en_o high) -> READ_WAIT.
- READ_WAIT: count RD_LAT cycles. On the final cycle, capture fb_rd_data_i into px_data_o, assert px_valid_o, and set px_last_o = (index == frame_len_o-1) -> READ_HOLD.
- READ_HOLD: hold px_data_o, px_valid_o and px_last_o stable until px_ready_i=1. On accept:
  - drop px_valid_o;
  - if last -> IDLE with done_o pulse;
  - else index+1 -> READ_ISSUE.
  - Throughput is 1 pixel per RD_LAT+2 cycles; that rate is sufficient for the host link.
- Read index width is ADDR+1 internally. fb_rd_addr_o = index[ADDR-1:0]. Index never exceeds frame_len_o-1.
- abort_i in any state -> IDLE next cycle. px_valid_o low next cycle, fb_rd_en_o high, no done_o. frame_len_o keeps its last value.
- abort_i wins over start_i in the same cycle. start_i outside IDLE is ignored.
- lv_i outside CAPTURE is ignored.
- fv_i glitch (low one cycle) during CAPTURE ends capture; the frame is treated as complete.
- Asynchronous reset mid-operation forces all reset values immediately. No pending done_o or timeout_o survives reset.

Decomposition:
- Package fb_ctrl_pkg holds:
  - state enum fb_ctrl_state_t (IDLE, WAIT_VBLANK, WAIT_FV, CAPTURE, READ_ISSUE, READ_WAIT, READ_HOLD);
  - default parameter constants;
  - helper function for saturating increment.
- One sub-module, fb_read_sequencer, owns READ_ISSUE/READ_WAIT/READ_HOLD, the read index and the px_* outputs.
  - Inputs: go pulse, length, abort.
  - Outputs: last-accepted pulse.
- Top module keeps the capture FSM, timeout counter and pixel counter.

Test Plan:
- Test 1: start; fv rises; 3 lines of 4 lv cycles; fv falls; px_ready_i=1.
  - frame_len_o=12; addresses 0..11 in order; px_data_o matches buffer model.
  - px_last_o on 12th beat; done_o one cycle after last accept.
- Test 2: start while fv_i=1 mid-frame with 7 lv cycles remaining.
  - Those pixels are not counted; capture begins on next fv rise; frame_len_o equals the next frame's count only.
- Test 3: 8-pixel frame; px_ready_i low 5 cycles while beat 3 valid.
  - px_data_o stable; fb_rd_addr_o stays 2; no beat lost or duplicated; 8 total beats.
- Test 4: TIMEOUT_CYCLES=100; start with fv_i stuck 0.
  - timeout_o pulses 100 cycles after entering WAIT_VBLANK; busy_o=0, fb_rd_en_o=1 after; no done_o.
- Test 5: abort_i during READ_HOLD at beat 4 -> px_valid_o=0 next cycle, IDLE, no done_o.
  - Separately: rst_n low mid-CAPTURE -> all outputs at reset values same cycle.
- Test 6: ADDR=12; frame of 5000 lv cycles -> frame_len_o=4096; last beat at address 4095.
  - Also: fv pulse with zero lv -> frame_len_o=0, done_o, no px_valid_o.
